// File: rtl/mux_key_pkg.sv
// Shared constants and helpers for the programmable key lookup table.
package mux_key_pkg;

  localparam int MK_MODE_OR   = 0;
  localparam int MK_MODE_PRIO = 1;

  // Index width never drops to zero, so a one-entry table still has a real index port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_key_match.sv
// Compare a key against all table entries and select data, hit flag and lowest matching index.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module mux_key_match
  import mux_key_pkg::*;
#(
  parameter int NR_KEY     = 4,
  parameter int KEY_LEN    = 4,
  parameter int DATA_LEN   = 8,
  parameter int MATCH_MODE = MK_MODE_PRIO,
  localparam int IDX_W     = idx_width(NR_KEY)
) (
  input  logic [KEY_LEN-1:0]  key,
  input  logic [KEY_LEN-1:0]  tbl_key  [NR_KEY],
  input  logic [DATA_LEN-1:0] tbl_data [NR_KEY],
  input  logic [NR_KEY-1:0]   tbl_vld,
  output logic [DATA_LEN-1:0] data,
  output logic                hit,
  output logic [IDX_W-1:0]    idx
);

  // Walking from the top entry down lets the lowest match overwrite everything above it.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    data = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (tbl_vld[i] && (tbl_key[i] == key)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
        if (MATCH_MODE == MK_MODE_PRIO) begin
          data = tbl_data[i];
        end else begin
          data = data | tbl_data[i];
        end
      end
    end
  end

endmodule

// File: rtl/mux_key_table.sv
// Runtime-programmable key->data lookup table with a registered valid/ready response.
// Latency: one cycle from request handshake to rsp_valid.
// Backpressure: single output register; req_ready drops only while a response is stalled.
module mux_key_table
  import mux_key_pkg::*;
#(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 8,
  parameter bit HAS_DEFAULT = 1'b1,
  parameter int MATCH_MODE  = MK_MODE_PRIO,
  localparam int IDX_W      = idx_width(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_wen,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [KEY_LEN-1:0]  cfg_key,
  input  logic [DATA_LEN-1:0] cfg_data,
  input  logic                cfg_vld,
  input  logic                cfg_clr,
  input  logic [DATA_LEN-1:0] default_out,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic [IDX_W-1:0]    rsp_idx
);

  logic [KEY_LEN-1:0]  tbl_key  [NR_KEY];
  logic [DATA_LEN-1:0] tbl_data [NR_KEY];
  logic [NR_KEY-1:0]   tbl_vld;

  logic                idx_ok;
  logic                req_fire;
  logic [DATA_LEN-1:0] match_data;
  logic                match_hit;
  logic [IDX_W-1:0]    match_idx;

  assign idx_ok    = (32'(cfg_idx) < NR_KEY);
  assign req_ready = !rsp_valid || rsp_ready;
  assign req_fire  = req_valid && req_ready;

  // Key/data payload needs no reset: an entry is only observable through its valid bit.
  always_ff @(posedge clk) begin
    if (cfg_wen && idx_ok) begin
      tbl_key[cfg_idx]  <= cfg_key;
      tbl_data[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_vld <= '0;
    end else if (cfg_clr) begin
      tbl_vld <= '0;
    end else if (cfg_wen && idx_ok) begin
      tbl_vld[cfg_idx] <= cfg_vld;
    end
  end

  mux_key_match #(
    .NR_KEY     (NR_KEY),
    .KEY_LEN    (KEY_LEN),
    .DATA_LEN   (DATA_LEN),
    .MATCH_MODE (MATCH_MODE)
  ) u_match (
    .key      (req_key),
    .tbl_key  (tbl_key),
    .tbl_data (tbl_data),
    .tbl_vld  (tbl_vld),
    .data     (match_data),
    .hit      (match_hit),
    .idx      (match_idx)
  );

  // The lookup reads the table as it stood before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
    end else if (req_fire) begin
      rsp_valid <= 1'b1;
      rsp_hit   <= match_hit;
      rsp_idx   <= match_idx;
      if (match_hit) begin
        rsp_data <= match_data;
      end else begin
        rsp_data <= HAS_DEFAULT ? default_out : '0;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_key_table.sv
// Bench for mux_key_table: a priority/default instance and an OR-merge/no-default 3-entry instance share stimulus.
module tb_mux_key_table;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_wen, cfg_vld, cfg_clr;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_key, req_key;
  logic [7:0] cfg_data, default_out;
  logic       req_valid, rsp_ready;

  logic       req_ready_p, rsp_valid_p, rsp_hit_p;
  logic [7:0] rsp_data_p;
  logic [1:0] rsp_idx_p;
  logic       req_ready_o, rsp_valid_o, rsp_hit_o;
  logic [7:0] rsp_data_o;
  logic [1:0] rsp_idx_o;

  int total = 0;
  int bad   = 0;

  logic [10:0] q_p[$];
  logic [10:0] q_o[$];
  logic [3:0]  m_key  [4];
  logic [7:0]  m_data [4];
  logic        m_vld  [4];

  always #5 clk = ~clk;

  mux_key_table #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1'b1), .MATCH_MODE(1)) dut_p (
    .clk(clk), .rst(rst), .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
    .cfg_data(cfg_data), .cfg_vld(cfg_vld), .cfg_clr(cfg_clr), .default_out(default_out),
    .req_valid(req_valid), .req_ready(req_ready_p), .req_key(req_key),
    .rsp_valid(rsp_valid_p), .rsp_ready(rsp_ready), .rsp_data(rsp_data_p),
    .rsp_hit(rsp_hit_p), .rsp_idx(rsp_idx_p)
  );

  mux_key_table #(.NR_KEY(3), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1'b0), .MATCH_MODE(0)) dut_o (
    .clk(clk), .rst(rst), .cfg_wen(cfg_wen), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
    .cfg_data(cfg_data), .cfg_vld(cfg_vld), .cfg_clr(cfg_clr), .default_out(default_out),
    .req_valid(req_valid), .req_ready(req_ready_o), .req_key(req_key),
    .rsp_valid(rsp_valid_o), .rsp_ready(rsp_ready), .rsp_data(rsp_data_o),
    .rsp_hit(rsp_hit_o), .rsp_idx(rsp_idx_o)
  );

  // Reference lookup over the bench's own copy of the table: {data, hit, idx}.
  function automatic logic [10:0] model(input int nr, input int mode, input bit hasdef,
                                        input logic [3:0] k, input logic [7:0] dflt);
    logic [7:0] d;
    logic [1:0] ix;
    logic       h;
    d = 8'h00; ix = 2'd0; h = 1'b0;
    for (int i = 0; i < nr; i++) begin
      if (m_vld[i] && m_key[i] == k) begin
        if (!h) begin
          ix = 2'(i);
          if (mode == 1) d = m_data[i];
        end
        if (mode == 0) d = d | m_data[i];
        h = 1'b1;
      end
    end
    if (!h) d = hasdef ? dflt : 8'h00;
    return {d, h, ix};
  endfunction

  // One clock: scoreboard at the negedge, then advance to just after the posedge.
  task automatic tick();
    logic [10:0] e;
    @(negedge clk);
    if (rst) begin
      q_p.delete();
      q_o.delete();
      for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
    end else begin
      if (q_p.size() != 0) begin
        total++;
        if (rsp_valid_p !== 1'b1) begin bad++; $display("FAIL latency_p rsp_valid=%b want 1", rsp_valid_p); end
      end
      if (q_o.size() != 0) begin
        total++;
        if (rsp_valid_o !== 1'b1) begin bad++; $display("FAIL latency_o rsp_valid=%b want 1", rsp_valid_o); end
      end
      if (rsp_valid_p === 1'b1 && rsp_ready) begin
        total++;
        if (q_p.size() == 0) begin
          bad++; $display("FAIL sb_p unexpected response got=%h want none", {rsp_data_p, rsp_hit_p, rsp_idx_p});
        end else begin
          e = q_p.pop_front();
          if ({rsp_data_p, rsp_hit_p, rsp_idx_p} !== e) begin
            bad++; $display("FAIL sb_p got=%h want=%h", {rsp_data_p, rsp_hit_p, rsp_idx_p}, e);
          end
        end
      end
      if (rsp_valid_o === 1'b1 && rsp_ready) begin
        total++;
        if (q_o.size() == 0) begin
          bad++; $display("FAIL sb_o unexpected response got=%h want none", {rsp_data_o, rsp_hit_o, rsp_idx_o});
        end else begin
          e = q_o.pop_front();
          if ({rsp_data_o, rsp_hit_o, rsp_idx_o} !== e) begin
            bad++; $display("FAIL sb_o got=%h want=%h", {rsp_data_o, rsp_hit_o, rsp_idx_o}, e);
          end
        end
      end
      if (req_valid && req_ready_p === 1'b1) q_p.push_back(model(4, 1, 1'b1, req_key, default_out));
      if (req_valid && req_ready_o === 1'b1) q_o.push_back(model(3, 0, 1'b0, req_key, default_out));
      if (cfg_clr) begin
        for (int i = 0; i < 4; i++) m_vld[i] = 1'b0;
      end else if (cfg_wen) begin
        m_key[cfg_idx] = cfg_key; m_data[cfg_idx] = cfg_data; m_vld[cfg_idx] = cfg_vld;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cfg_wen = 1'b0; cfg_clr = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0; idle();
    cfg_idx = '0; cfg_key = '0; cfg_data = '0; cfg_vld = 1'b0; req_key = '0; default_out = 8'hEE;
    tick(); tick();
    total++;
    if ({rsp_valid_p, rsp_data_p, rsp_hit_p, rsp_idx_p} !== 12'h000)
      begin bad++; $display("FAIL reset_p got=%h want=000", {rsp_valid_p, rsp_data_p, rsp_hit_p, rsp_idx_p}); end
    total++;
    if ({rsp_valid_o, rsp_data_o, rsp_hit_o, rsp_idx_o} !== 12'h000)
      begin bad++; $display("FAIL reset_o got=%h want=000", {rsp_valid_o, rsp_data_o, rsp_hit_o, rsp_idx_o}); end
    rst = 1'b0;
    tick();
    total++;
    if (req_ready_p !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready_p); end
  endtask

  task automatic test_miss_default();
    rsp_ready = 1'b1; req_valid = 1'b1; req_key = 4'h3; default_out = 8'hEE;
    tick();
    idle();
    total++;
    if ({rsp_valid_p, rsp_data_p, rsp_hit_p, rsp_idx_p} !== {1'b1, 8'hEE, 1'b0, 2'd0})
      begin bad++; $display("FAIL miss_p got=%h want=%h", {rsp_valid_p, rsp_data_p, rsp_hit_p, rsp_idx_p}, {1'b1, 8'hEE, 1'b0, 2'd0}); end
    total++;
    if (rsp_data_o !== 8'h00) begin bad++; $display("FAIL miss_nodefault got=%h want=00", rsp_data_o); end
    tick();
  endtask

  task automatic test_write_lookup();
    cfg_wen = 1'b1; cfg_idx = 2'd1; cfg_key = 4'h3; cfg_data = 8'hA5; cfg_vld = 1'b1;
    req_valid = 1'b1; req_key = 4'h3;
    tick();
    cfg_wen = 1'b0;
    total++;
    if (rsp_hit_p !== 1'b0) begin bad++; $display("FAIL same_cycle_write hit=%b want=0", rsp_hit_p); end
    tick();
    idle();
    total++;
    if ({rsp_data_p, rsp_hit_p, rsp_idx_p} !== {8'hA5, 1'b1, 2'd1})
      begin bad++; $display("FAIL write_hit got=%h want=%h", {rsp_data_p, rsp_hit_p, rsp_idx_p}, {8'hA5, 1'b1, 2'd1}); end
    tick();
  endtask

  task automatic test_match_mode();
    cfg_wen = 1'b1; cfg_vld = 1'b1; cfg_key = 4'h5;
    cfg_idx = 2'd0; cfg_data = 8'h0F; tick();
    cfg_idx = 2'd2; cfg_data = 8'hF0; tick();
    cfg_wen = 1'b0; req_valid = 1'b1; req_key = 4'h5;
    tick();
    idle();
    total++;
    if ({rsp_data_p, rsp_idx_p} !== {8'h0F, 2'd0})
      begin bad++; $display("FAIL prio got=%h want=%h", {rsp_data_p, rsp_idx_p}, {8'h0F, 2'd0}); end
    total++;
    if ({rsp_data_o, rsp_hit_o, rsp_idx_o} !== {8'hFF, 1'b1, 2'd0})
      begin bad++; $display("FAIL or_merge got=%h want=%h", {rsp_data_o, rsp_hit_o, rsp_idx_o}, {8'hFF, 1'b1, 2'd0}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] snap_p, snap_o;
    logic [3:0]  keys [4];
    keys[0] = 4'h3; keys[1] = 4'h5; keys[2] = 4'hC; keys[3] = 4'h3;
    rsp_ready = 1'b0; req_valid = 1'b1; req_key = 4'h5;
    tick();
    snap_p = {rsp_valid_p, rsp_data_p, rsp_hit_p, rsp_idx_p};
    snap_o = {rsp_valid_o, rsp_data_o, rsp_hit_o, rsp_idx_o};
    for (int i = 0; i < 3; i++) begin
      req_key = keys[i];
      #1;
      total++;
      if (req_ready_p !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b want=0", i, req_ready_p); end
      tick();
      total++;
      if ({rsp_valid_p, rsp_data_p, rsp_hit_p, rsp_idx_p} !== snap_p || {rsp_valid_o, rsp_data_o, rsp_hit_o, rsp_idx_o} !== snap_o)
        begin bad++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, {rsp_valid_p, rsp_data_p, rsp_hit_p, rsp_idx_p}, snap_p); end
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_key = keys[i];
      #1;
      total++;
      if (req_ready_p !== 1'b1) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b want=1", i, req_ready_p); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_clear_oob();
    cfg_clr = 1'b1; cfg_wen = 1'b1; cfg_idx = 2'd1; cfg_key = 4'h3; cfg_data = 8'hA5; cfg_vld = 1'b1;
    tick();
    idle(); req_valid = 1'b1; req_key = 4'h3;
    tick();
    idle();
    total++;
    if (rsp_hit_p !== 1'b0) begin bad++; $display("FAIL clr_wins hit=%b want=0", rsp_hit_p); end
    cfg_wen = 1'b1; cfg_idx = 2'd3; cfg_key = 4'h7; cfg_data = 8'h77; cfg_vld = 1'b1;
    tick();
    idle(); req_valid = 1'b1; req_key = 4'h7;
    tick();
    idle();
    total++;
    if ({rsp_hit_p, rsp_idx_p, rsp_data_p} !== {1'b1, 2'd3, 8'h77})
      begin bad++; $display("FAIL idx3_p got=%h want=%h", {rsp_hit_p, rsp_idx_p, rsp_data_p}, {1'b1, 2'd3, 8'h77}); end
    total++;
    if ({rsp_hit_o, rsp_data_o} !== 9'h000) begin bad++; $display("FAIL oob_ignored got=%h want=000", {rsp_hit_o, rsp_data_o}); end
    tick();
  endtask

  task automatic test_reset_pending();
    cfg_wen = 1'b1; cfg_idx = 2'd0; cfg_key = 4'h9; cfg_data = 8'h99; cfg_vld = 1'b1;
    tick();
    idle(); rsp_ready = 1'b0; req_valid = 1'b1; req_key = 4'h9;
    tick();
    idle();
    total++;
    if ({rsp_valid_p, rsp_hit_p} !== 2'b11) begin bad++; $display("FAIL pend_setup got=%b want=11", {rsp_valid_p, rsp_hit_p}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({rsp_valid_p, rsp_valid_o} !== 2'b00) begin bad++; $display("FAIL rst_drop got=%b want=00", {rsp_valid_p, rsp_valid_o}); end
    rsp_ready = 1'b1; req_valid = 1'b1; req_key = 4'h9; default_out = 8'h5A;
    tick();
    idle();
    total++;
    if ({rsp_hit_p, rsp_data_p} !== {1'b0, 8'h5A}) begin bad++; $display("FAIL rst_invalid got=%h want=%h", {rsp_hit_p, rsp_data_p}, {1'b0, 8'h5A}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_miss_default();
    test_write_lookup();
    test_match_mode();
    test_back_to_back();
    test_clear_oob();
    test_reset_pending();
    idle(); rsp_ready = 1'b1;
    for (int i = 0; i < 10 && (q_p.size() != 0 || q_o.size() != 0); i++) tick();
    total++;
    if (q_p.size() != 0 || q_o.size() != 0)
      begin bad++; $display("FAIL drain left=%0d/%0d want 0/0", q_p.size(), q_o.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
